rate_ctrl: RTL

RATE_CTRL -- requirements
Module: rate_ctrl

---
 rtl/rate_ctrl_pkg.sv | 6 +
 rtl/rate_prescaler.sv | 23 ++
 rtl/rate_ctrl.sv | 89 ++++++++
 3 files changed

// File: rtl/rate_ctrl_pkg.sv
// rate_ctrl_pkg: shared widths, default divisor and FSM encoding for rate_ctrl.
package rate_ctrl_pkg;
    localparam int CNT_W = 25;
    localparam logic [CNT_W-1:0] DEFAULT_DIV = 25'd25_000_000;
    typedef enum logic [1:0] {IDLE, RUN, PEND} state_e;
endpackage

// File: rtl/rate_prescaler.sv
// rate_prescaler: half-period counter that wraps to 0 after reaching div-1.
module rate_prescaler #(
    parameter int CNT_W = rate_ctrl_pkg::CNT_W
) (
    input  logic             c,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] div,
    output logic [CNT_W-1:0] count,
    output logic             term
);
    logic [CNT_W-1:0] count_q, count_d;
    assign term  = en && (count_q == div - CNT_W'(1));
    assign count = count_q;
    always_comb begin
        count_d = clr ? '0 : !en ? count_q : term ? '0 : count_q + CNT_W'(1);
    end
    always_ff @(posedge c) begin
        if (!reset) count_q <= '0;
        else        count_q <= count_d;
    end
endmodule

// File: rtl/rate_ctrl.sv
// rate_ctrl: start/stop tick generator with a ready/valid divisor update that takes effect at a period boundary.
module rate_ctrl #(
    parameter int               CNT_W       = rate_ctrl_pkg::CNT_W,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(rate_ctrl_pkg::DEFAULT_DIV)
) (
    input  logic             c,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic [CNT_W-1:0] count,
    output logic             clk_out,
    output logic             tick,
    output logic             running,
    output logic             err
);
    import rate_ctrl_pkg::*;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] div_q, div_d, pend_q, pend_d;
    logic             clk_out_q, clk_out_d, tick_q, tick_d, err_q, err_d, cfg_ready_q, cfg_ready_d;
    logic             run, acc, bad, good, term;
    assign run  = state_q != IDLE;
    assign acc  = cfg_valid && cfg_ready_q;
    assign bad  = acc && (cfg_div == '0);
    assign good = acc && !bad;
    rate_prescaler #(.CNT_W(CNT_W)) u_pre (
        .c     (c),
        .reset (reset),
        .clr   (!run || stop),
        .en    (run),
        .div   (div_q),
        .count (count),
        .term  (term)
    );
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        pend_d    = pend_q;
        clk_out_d = clk_out_q;
        tick_d    = 1'b0;
        err_d     = err_q || bad;
        if (!run) begin
            div_d   = good ? cfg_div : div_q;
            state_d = (start && !stop) ? RUN : IDLE;
        end else if (stop) begin
            // A pending divisor is never lost: stop applies it right away.
            state_d   = IDLE;
            clk_out_d = 1'b0;
            div_d     = (state_q == PEND) ? pend_q : good ? cfg_div : div_q;
        end else begin
            clk_out_d = term ? !clk_out_q : clk_out_q;
            tick_d    = term;
            if (state_q == PEND && term) begin
                div_d   = pend_q;
                state_d = RUN;
            end else if (state_q == RUN && good) begin
                pend_d  = cfg_div;
                state_d = PEND;
            end
        end
        cfg_ready_d = state_d != PEND;
    end
    always_ff @(posedge c) begin
        if (!reset) begin
            state_q     <= IDLE;
            div_q       <= DEFAULT_DIV;
            pend_q      <= '0;
            clk_out_q   <= 1'b0;
            tick_q      <= 1'b0;
            err_q       <= 1'b0;
            cfg_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            pend_q      <= pend_d;
            clk_out_q   <= clk_out_d;
            tick_q      <= tick_d;
            err_q       <= err_d;
            cfg_ready_q <= cfg_ready_d;
        end
    end
    assign cfg_ready = cfg_ready_q;
    assign clk_out   = clk_out_q;
    assign tick      = tick_q;
    assign running   = run;
    assign err       = err_q;
endmodule
